core_inst_seq: RTL and testbench

Hardware instruction sequencer that drives the core's 34-bit `inst` bus for a full convolution tile, replacing the hand-stepped bench stimulus.
- Sits directly upstream of `core`: for every kernel index kij it issues weight fetch to IFIFO, weight load into the PE array, activation fetch to L0, execution, and OFIFO drain into psum memory.
- Output accumulation is out of scope and belongs to a separate block.
- Activations and all kij weight tiles are already resident in xmem before `start`.

---
 rtl/core_inst_seq.sv | 149 ++++++++++++++
 tb/tb_core_inst_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one convolution tile: for each kij it streams weight
// fetch, weight load, activation fetch, execute and OFIFO drain words onto core's inst bus.
module core_inst_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_nij  = 36,
    parameter int len_kij  = 9,
    parameter int act_base = 0,
    parameter int wgt_base = 1024,
    parameter int load_gap = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij
);

    localparam int          TW        = 8;
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
    localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WIFIFO, S_GAPW, S_WLOAD, S_GAPL, S_AL0, S_GAPA,
        S_EXEC, S_GAPE, S_WAITOV, S_ORD, S_GAPO, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [3:0]      kij_q, kij_d;
    logic [33:0]     inst_q, inst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            last;

    function automatic int phase_len(input state_t s);
        case (s)
            S_WIFIFO: return col;
            S_WLOAD:  return row + 2 * col;
            S_GAPL:   return load_gap;
            S_AL0:    return len_nij;
            S_EXEC:   return len_nij + row + col;
            S_ORD:    return len_nij;
            default:  return 1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        t_d     = '0;
        kij_d   = kij_q;
        last    = (32'(t_q) == 32'(phase_len(state_q) - 1));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WIFIFO;
                    kij_d   = '0;
                end
            end
            S_WAITOV: if (ofifo_valid) state_d = S_ORD;
            S_DONE:   state_d = S_IDLE;
            default: begin
                if (!last) begin
                    t_d = t_q + 1'b1;
                end else begin
                    case (state_q)
                        S_WIFIFO: state_d = S_GAPW;
                        S_GAPW:   state_d = S_WLOAD;
                        S_WLOAD:  state_d = S_GAPL;
                        S_GAPL:   state_d = S_AL0;
                        S_AL0:    state_d = S_GAPA;
                        S_GAPA:   state_d = S_EXEC;
                        S_EXEC:   state_d = S_GAPE;
                        S_GAPE:   state_d = S_WAITOV;
                        S_ORD:    state_d = S_GAPO;
                        S_GAPO: begin
                            if (kij_q == KIJ_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_WIFIFO;
                                kij_d   = kij_q + 4'd1;
                            end
                        end
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        // Outputs are decoded from the next state so inst lines up with state_q.
        inst_d = IDLE_WORD;
        case (state_d)
            S_WIFIFO: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = 11'(32'(wgt_base) + 32'(kij_d) * 32'(col) + 32'(t_d));
                inst_d[5]    = 1'b1;
            end
            S_WLOAD: begin
                inst_d[4] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_AL0: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = 11'(32'(act_base) + 32'(t_d));
                inst_d[2]    = 1'b1;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_ORD: begin
                inst_d[32]    = 1'b0;
                inst_d[31]    = 1'b0;
                inst_d[30:20] = 11'(32'(kij_d) * 32'(len_nij) + 32'(t_d));
                inst_d[6]     = 1'b1;
            end
            default: inst_d = IDLE_WORD;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            kij_q   <= '0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            kij_q   <= kij_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign kij  = kij_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: checkpoint table from the default-parameter schedule, hand
// sequences for handshake/reset/start corner cases, and a cycle-level reference model.
module tb_core_inst_seq;

    localparam int R = 8, C = 8, N = 36, K = 9, G = 11;
    localparam int WGT = 1024, ACT = 0;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    // Pre-WAITOV words per kij: WIFIFO, GAP1, WLOAD, GAPL, AL0, GAP1, EXEC, GAP1
    localparam int PRE_LEN  = C + 1 + (R + 2 * C) + G + N + 1 + (N + R + C) + 1;
    localparam int POST_LEN = N + 1;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [33:0] inst;
    logic        busy, done;
    logic [3:0]  kij;

    int checks = 0, errors = 0;
    int rel = 0;

    core_inst_seq dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .kij(kij)
    );

    always #5 clk = ~clk;

    // Reference model: running flag, DONE flag, kij, segment (0 pre, 1 wait, 2 ORD+gap), index
    bit m_run = 0, m_done = 0;
    int m_kij = 0, m_seg = 0, m_i = 0;

    function automatic logic [33:0] mkw(input bit cp, wp, input int ap, input bit cx, wx,
                                        input int ax, input logic [6:0] lo);
        logic [10:0] a_p, a_x;
        a_p = 11'(ap);
        a_x = 11'(ax);
        return {1'b0, cp, wp, a_p, cx, wx, a_x, lo};
    endfunction

    function automatic logic [33:0] pre_word(input int k, input int i);
        int b_ld, b_gl, b_al, b_ex;
        b_ld = C + 1;
        b_gl = b_ld + R + 2 * C;
        b_al = b_gl + G;
        b_ex = b_al + N + 1;
        if (i < C)                  return mkw(1, 1, 0, 0, 1, WGT + k * C + i, 7'h20);
        if (i >= b_ld && i < b_gl)  return mkw(1, 1, 0, 1, 1, 0, 7'h11);
        if (i >= b_al && i < b_al + N) return mkw(1, 1, 0, 0, 1, ACT + i - b_al, 7'h04);
        if (i >= b_ex && i < b_ex + N + R + C) return mkw(1, 1, 0, 1, 1, 0, 7'h0A);
        return IDLE_W;
    endfunction

    function automatic logic [33:0] post_word(input int k, input int i);
        if (i < N) return mkw(0, 0, k * N + i, 1, 1, 0, 7'h40);
        return IDLE_W;
    endfunction

    task automatic model_adv(input bit st, input bit ov, input bit rs);
        if (rs) begin
            m_run = 0; m_done = 0; m_kij = 0; m_seg = 0; m_i = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (st) begin m_run = 1; m_kij = 0; m_seg = 0; m_i = 0; end
        end else if (m_seg == 0) begin
            m_i++;
            if (m_i == PRE_LEN) m_seg = 1;
        end else if (m_seg == 1) begin
            if (ov) begin m_seg = 2; m_i = 0; end
        end else begin
            m_i++;
            if (m_i == POST_LEN) begin
                if (m_kij == K - 1) begin m_run = 0; m_done = 1; end
                else begin m_kij++; m_seg = 0; m_i = 0; end
            end
        end
    endtask

    task automatic model_check();
        logic [33:0] ew;
        if (m_run && m_seg == 0)      ew = pre_word(m_kij, m_i);
        else if (m_run && m_seg == 2) ew = post_word(m_kij, m_i);
        else                          ew = IDLE_W;
        checks++;
        if (inst !== ew || busy !== (m_run | m_done) || done !== m_done || kij !== 4'(m_kij)) begin
            errors++;
            $display("FAIL model rel=%0d: got inst=%h busy=%b done=%b kij=%0d, want inst=%h busy=%b done=%b kij=%0d",
                     rel, inst, busy, done, kij, ew, m_run | m_done, m_done, m_kij);
        end
    endtask

    task automatic hand(input string name, input logic [33:0] w, input bit b, input bit d, input int k);
        checks++;
        if (inst !== w || busy !== b || done !== d || kij !== 4'(k)) begin
            errors++;
            $display("FAIL %s rel=%0d: got inst=%h busy=%b done=%b kij=%0d, want inst=%h busy=%b done=%b kij=%0d",
                     name, rel, inst, busy, done, kij, w, b, d, k);
        end
    endtask

    // One clock: drive inputs, model the edge, then compare at the falling edge.
    task automatic cyc(input bit st, input bit ov, input bit rs);
        start = st; ofifo_valid = ov; reset = rs;
        @(posedge clk);
        model_adv(st, ov, rs);
        @(negedge clk);
        rel++;
        model_check();
    endtask

    typedef struct {
        int          cyc;
        logic [33:0] w;
        bit          b;
        bit          d;
        int          k;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int c, input logic [33:0] w, input bit b, input bit d, input int k);
        vec_t v;
        v.cyc = c; v.w = w; v.b = b; v.d = d; v.k = k;
        tbl.push_back(v);
    endtask

    initial begin
        int ndone;
        add(1,    34'h1_8006_0020, 1, 0, 0);
        add(8,    34'h1_8006_03A0, 1, 0, 0);
        add(9,    IDLE_W,          1, 0, 0);
        add(10,   34'h1_800C_0011, 1, 0, 0);
        add(33,   34'h1_800C_0011, 1, 0, 0);
        add(34,   IDLE_W,          1, 0, 0);
        add(44,   IDLE_W,          1, 0, 0);
        add(45,   34'h1_8004_0004, 1, 0, 0);
        add(80,   34'h1_8004_1184, 1, 0, 0);
        add(81,   IDLE_W,          1, 0, 0);
        add(82,   34'h1_800C_000A, 1, 0, 0);
        add(133,  34'h1_800C_000A, 1, 0, 0);
        add(134,  IDLE_W,          1, 0, 0);
        add(135,  IDLE_W,          1, 0, 0);
        add(136,  34'h0_000C_0040, 1, 0, 0);
        add(171,  34'h0_023C_0040, 1, 0, 0);
        add(172,  IDLE_W,          1, 0, 0);
        add(173,  34'h1_8006_0420, 1, 0, 1);
        add(1377, 34'h1_8006_2020, 1, 0, 8);
        add(1384, 34'h1_8006_23A0, 1, 0, 8);
        add(1512, 34'h0_120C_0040, 1, 0, 8);
        add(1547, 34'h0_143C_0040, 1, 0, 8);
        add(1548, IDLE_W,          1, 0, 8);
        add(1549, IDLE_W,          1, 1, 8);
        add(1550, IDLE_W,          0, 0, 8);

        start = 0; ofifo_valid = 0; reset = 1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        hand("reset_state", IDLE_W, 0, 0, 0);

        // Full run against the checkpoint table, ofifo_valid tied high
        rel = 0;
        cyc(1, 1, 0);
        foreach (tbl[i]) begin
            while (rel < tbl[i].cyc) cyc(0, 1, 0);
            hand("table", tbl[i].w, tbl[i].b, tbl[i].d, tbl[i].k);
        end

        // Handshake: WAITOV held 20 cycles with ofifo_valid low
        rel = 0;
        cyc(1, 0, 0);
        while (rel < 154) cyc(0, 0, 0);
        hand("waitov_hold", IDLE_W, 1, 0, 0);
        cyc(0, 1, 0);
        hand("ord_after_valid", 34'h0_000C_0040, 1, 0, 0);
        repeat (5) cyc(0, 1, 0);
        cyc(0, 1, 1);

        // Reset held 3 cycles in EXEC
        rel = 0;
        cyc(1, 1, 0);
        while (rel < 100) cyc(0, 1, 0);
        repeat (3) cyc(0, 1, 1);
        cyc(0, 1, 0);
        hand("reset_mid_exec", IDLE_W, 0, 0, 0);
        repeat (30) cyc(0, 1, 0);
        hand("no_resume", IDLE_W, 0, 0, 0);

        // Start pulse during WLOAD of kij 3, then start in DONE and on the cycle after
        rel = 0;
        ndone = 0;
        cyc(1, 1, 0);
        while (rel < 1549) begin
            cyc(rel == 3 * 172 + 15, 1, 0);
            if (done) ndone++;
        end
        hand("busy_start_done", IDLE_W, 1, 1, 8);
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, want 1", ndone);
        end
        cyc(1, 1, 0);
        hand("start_in_done", IDLE_W, 0, 0, 8);
        cyc(1, 1, 0);
        hand("back_to_back", 34'h1_8006_0020, 1, 0, 0);
        rel = 1;
        while (rel < 1549) cyc(0, 1, 0);
        hand("b2b_done", IDLE_W, 1, 1, 8);

        // Randomized traffic against the model
        for (int n = 0; n < 8000; n++)
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2999) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
